uart_rx: RTL

- UART receiver (8N1) that feeds the 16-character LCD text row buffer.
- Oversamples the serial line on the system clock and reassembles each byte.
- Presents each byte on o_RX_Data with a level-held o_RX_DataValid strobe, which the row buffer catches with its own 2-FF rising-edge detector.
- Reports stop-bit framing errors and recovers from line breaks.

---
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx.sv | 115 +++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Serial-line and byte-output bundle of the 8N1 UART receiver.
// The slave side is the receiver; the master side drives the line and reads the bytes.
interface uart_rx_if;
  logic       i_uart_rx;
  logic [7:0] o_RX_Data;
  logic       o_RX_DataValid;
  logic       o_frameError;

  modport slave (
    input  i_uart_rx,
    output o_RX_Data,
    output o_RX_DataValid,
    output o_frameError
  );

  modport master (
    output i_uart_rx,
    input  o_RX_Data,
    input  o_RX_DataValid,
    input  o_frameError
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop decode with a level-held valid window,
// stop-bit framing-error pulse and break recovery.
module uart_rx #(
  parameter int CLKS_PER_BIT = 234,
  parameter int VALID_HOLD   = 4
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HW = $clog2(VALID_HOLD + 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state;
  state_t        state_next;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic [HW-1:0] hold_cnt;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          ferr_q;
  logic          shift_en;
  logic          good_stop;
  logic          bad_stop;

  // Synchroniser resets to the idle-high level so reset never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!rx_s) state_next = START;
      START: if (clk_cnt == HALF) state_next = rx_s ? IDLE : DATA;
      DATA:  if (clk_cnt == LAST && bit_idx == 3'd7) state_next = STOP;
      STOP:  if (clk_cnt == LAST) state_next = rx_s ? IDLE : BREAK;
      BREAK: if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shift_en  = (state == DATA) && (clk_cnt == LAST);
    good_stop = (state == STOP) && (clk_cnt == LAST) && rx_s;
    bad_stop  = (state == STOP) && (clk_cnt == LAST) && !rx_s;
  end

  // Bit timing: the counter restarts on every state change and wraps once per bit period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_cnt   <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      if (state_next != state || state == IDLE || state == BREAK || clk_cnt == LAST)
        clk_cnt <= '0;
      else
        clk_cnt <= clk_cnt + 1'b1;

      if (state != DATA)
        bit_idx <= 3'd0;
      else if (shift_en)
        bit_idx <= bit_idx + 3'd1;

      if (shift_en)
        shift_reg[bit_idx] <= rx_s;
    end
  end

  // Valid window runs off its own counter so a back-to-back start bit never truncates it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q   <= 8'h00;
      hold_cnt <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      ferr_q <= bad_stop;
      if (good_stop) begin
        data_q   <= shift_reg;
        hold_cnt <= HW'(VALID_HOLD);
        valid_q  <= 1'b1;
      end else begin
        if (hold_cnt != '0)
          hold_cnt <= hold_cnt - 1'b1;
        valid_q <= (hold_cnt > HW'(1));
      end
    end
  end

  assign bus.o_RX_Data      = data_q;
  assign bus.o_RX_DataValid = valid_q;
  assign bus.o_frameError   = ferr_q;

endmodule
